// File: rtl/tap_pkg.sv
// tap_pkg: shared types and default constants for the memory write tap.
// Holds the capture FSM states, framing symbols, test-port address and event record.
package tap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } tap_state_e;

    localparam logic [29:0] TAP_PORT_ADDR = 30'h40;
    localparam logic [31:0] TAP_BEGIN_SYM = 32'h0000_0932;
    localparam logic [31:0] TAP_END_SYM   = 32'h0000_0D5D;

    typedef struct packed {
        logic [7:0]  index;
        logic [31:0] data;
    } tap_event_t;

endpackage

// File: rtl/mem_write_tap_if.sv
// mem_write_tap_if: data-bus write side plus the event valid/ready stream.
// master = the tap (reads bus, drives events); slave = bus driver / checker.
interface mem_write_tap_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wen;
    logic              ev_valid;
    logic              ev_ready;
    logic [DATA_W-1:0] ev_data;
    logic [IDX_W-1:0]  ev_index;

    modport master (
        input  mem_addr, mem_wdata, mem_wen, ev_ready,
        output ev_valid, ev_data, ev_index
    );

    modport slave (
        output mem_addr, mem_wdata, mem_wen, ev_ready,
        input  ev_valid, ev_data, ev_index
    );
endinterface

// File: rtl/tap_fifo.sv
// tap_fifo: synchronous FIFO, DEPTH entries of W bits, registered head.
// Ports: clk, rst, push/din, pop, full, empty, head (zero while empty).
module tap_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer tells full from empty.
    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic         wr, rd;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head  = empty ? '0 : mem_q[rd_q[AW-1:0]];

    always_comb begin
        // A pop frees the slot in the same cycle, so push on full succeeds.
        wr    = push & (~full | pop);
        rd    = pop & ~empty;
        mem_d = mem_q;
        if (wr) mem_d[wr_q[AW-1:0]] = din;
        wr_d  = wr_q + (AW+1)'(wr);
        rd_d  = rd_q + (AW+1)'(rd);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/mem_write_tap.sv
// mem_write_tap: passive monitor turning test-port writes into framed events.
// Ports: clk, rst, bus (mem_* in, ev_* stream out), active, done, overflow,
// duration, timeout. Optional idle watchdog enabled by TAP_TIMEOUT_EN.
module mem_write_tap
    import tap_pkg::*;
#(
    parameter int                ADDR_W    = 30,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] PORT_ADDR = TAP_PORT_ADDR,
    parameter logic [DATA_W-1:0] BEGIN_SYM = TAP_BEGIN_SYM,
    parameter logic [DATA_W-1:0] END_SYM   = TAP_END_SYM,
    parameter int                DEPTH     = 4,
    parameter int                IDX_W     = 8
`ifdef TAP_TIMEOUT_EN
    ,
    parameter int                TIMEOUT   = 1024
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_write_tap_if.master       bus,
    output logic                  active,
    output logic                  done,
    output logic                  overflow,
    output logic [15:0]           duration,
    output logic                  timeout
);
    localparam int EW = IDX_W + DATA_W;

    tap_state_e       state_q, state_d;
    logic             wen_q;
    logic [IDX_W-1:0] index_q, index_d;
    logic [15:0]      dur_q, dur_d;
    logic             ovf_q, ovf_d;
    logic             evt, push, pop, full, empty;
    logic [EW-1:0]    head;

`ifdef TAP_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT);
    logic [IW-1:0] idle_q, idle_d;
    logic          tmo_q, tmo_d;
`endif

    // Rising edge of wen at the port: a stalled, held-high write counts once.
    assign evt = bus.mem_wen & ~wen_q & (bus.mem_addr == PORT_ADDR);
    assign pop = ~empty & bus.ev_ready;

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        dur_d   = dur_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
`ifdef TAP_TIMEOUT_EN
        idle_d  = '0;
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (evt && bus.mem_wdata == BEGIN_SYM)
                    state_d = CAPTURE;
            end
            CAPTURE: begin
                if (dur_q != 16'hFFFF) dur_d = dur_q + 16'd1;
                if (evt) begin
                    // Index advances even on a drop so gaps are visible.
                    push    = 1'b1;
                    index_d = index_q + IDX_W'(1);
                    if (full && !pop) ovf_d = 1'b1;
                    if (bus.mem_wdata == END_SYM) state_d = DONE;
                end
`ifdef TAP_TIMEOUT_EN
                if (evt) begin
                    idle_d = '0;
                end else if (idle_q == IW'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
`endif
            end
            DONE: ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wen_q   <= 1'b0;
            index_q <= '0;
            dur_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wen_q   <= bus.mem_wen;
            index_q <= index_d;
            dur_q   <= dur_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef TAP_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            idle_q <= idle_d;
            tmo_q  <= tmo_d;
        end
    end

    assign timeout = tmo_q;
`else
    assign timeout = 1'b0;
`endif

    tap_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({index_q, bus.mem_wdata}),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign bus.ev_valid = ~empty;
    assign bus.ev_index = head[EW-1 -: IDX_W];
    assign bus.ev_data  = head[DATA_W-1:0];

    assign active   = (state_q == CAPTURE);
    assign done     = (state_q == DONE);
    assign overflow = ovf_q;
    assign duration = dur_q;
endmodule
